// File: rtl/config_chain_readback_pkg.sv
// Shared types and helpers for the configuration-chain readback block.
package config_chain_readback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width needed to hold the values 0..n inclusive, so a counter can reach n without wrapping.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/config_chain_readback_packer.sv
// Packs serial chain bits LSB-first into one output word and counts bits within the word.
module readback_word_packer
  import config_chain_readback_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cap_i,
  input  logic                            clr_i,
  input  logic                            bit_i,
  output logic [WORD_W-1:0]               word_o,
  output logic [cnt_width(WORD_W)-1:0]    cnt_o
);

  localparam int KW = cnt_width(WORD_W);

  logic [WORD_W-1:0] word_q, word_d;
  logic [KW-1:0]     cnt_q, cnt_d;

  // Next word: clear wins over capture; capture writes bit position cnt_q only.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = {WORD_W{1'b0}};
      cnt_d  = {KW{1'b0}};
    end else if (cap_i) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (cnt_q == KW'(i)) begin
          word_d[i] = bit_i;
        end else begin
          word_d[i] = word_q[i];
        end
      end
      cnt_d = cnt_q + KW'(1);
    end else begin
      word_d = word_q;
      cnt_d  = cnt_q;
    end
  end

  // Word and in-word counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= {WORD_W{1'b0}};
      cnt_q  <= {KW{1'b0}};
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/config_chain_readback.sv
// Reads a recirculating configuration scan chain and streams it out as WORD_W-bit words.
module config_chain_readback
  import config_chain_readback_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sc_out,
  output logic              sc_en,
  output logic              sc_in,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy,
  output logic              done
);

  localparam int TW = cnt_width(CHAIN_LEN);
  localparam int KW = cnt_width(WORD_W);

  state_e         state_q, state_d;
  logic [TW-1:0]  tot_q, tot_d;
  logic           cap_s, clr_s;
  logic [KW-1:0]  wcnt_s;

  // The chain head is fed from its tail so a full pass restores the contents.
  assign sc_in = sc_out;

  readback_word_packer #(.WORD_W(WORD_W)) u_packer (
    .clk    (clk),
    .reset  (reset),
    .cap_i  (cap_s),
    .clr_i  (clr_s),
    .bit_i  (sc_out),
    .word_o (data_o),
    .cnt_o  (wcnt_s)
  );

  // Next-state, total-bit counter and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    tot_d   = tot_q;
    cap_s   = 1'b0;
    clr_s   = 1'b0;
    sc_en   = 1'b0;
    valid_o = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_SHIFT;
          tot_d   = {TW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sc_en = 1'b1;
        cap_s = 1'b1;
        tot_d = tot_q + TW'(1);
        // Leave after this capture if the word fills or the chain is exhausted.
        if ((wcnt_s == KW'(WORD_W - 1)) || (tot_q == TW'(CHAIN_LEN - 1))) begin
          state_d = ST_PUSH;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_PUSH: begin
        valid_o = 1'b1;
        if (ready_i) begin
          clr_s = 1'b1;
          if (tot_q == TW'(CHAIN_LEN)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_PUSH;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        tot_d   = {TW{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        tot_d   = {TW{1'b0}};
      end
    endcase
  end

  // State and total-bit counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tot_q   <= {TW{1'b0}};
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
    end
  end

endmodule

// File: tb/tb_config_chain_readback.sv
// Directed bench: two instances (16/8 and 12/8) against behavioural chain models.
module tb_config_chain_readback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start16, ready16, sc_out16, sc_en16, sc_in16, valid16, busy16, done16;
  logic start12, ready12, sc_out12, sc_en12, sc_in12, valid12, busy12, done12;
  logic [7:0]  data16, data12;
  logic [15:0] chain16;
  logic [11:0] chain12;

  int checks = 0;
  int errors = 0;
  int en16, en12, dn16, dn12;
  logic [7:0] words16[$];
  logic [7:0] words12[$];

  assign sc_out16 = chain16[0];
  assign sc_out12 = chain12[0];

  config_chain_readback #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sc_out(sc_out16), .sc_en(sc_en16),
    .sc_in(sc_in16), .data_o(data16), .valid_o(valid16), .ready_i(ready16),
    .busy(busy16), .done(done16)
  );

  config_chain_readback #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .clk(clk), .reset(reset), .start(start12), .sc_out(sc_out12), .sc_en(sc_en12),
    .sc_in(sc_in12), .data_o(data12), .valid_o(valid12), .ready_i(ready12),
    .busy(busy12), .done(done12)
  );

  // Chain models plus monitors for shift cycles, accepted words and done pulses.
  always @(posedge clk) begin
    if (sc_en16) begin
      chain16 <= {sc_in16, chain16[15:1]};
      en16    <= en16 + 1;
    end
    if (sc_en12) begin
      chain12 <= {sc_in12, chain12[11:1]};
      en12    <= en12 + 1;
    end
    if (valid16 && ready16) words16.push_back(data16);
    if (valid12 && ready12) words12.push_back(data12);
    if (done16) dn16 <= dn16 + 1;
    if (done12) dn12 <= dn12 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    en16 = 0; en12 = 0; dn16 = 0; dn12 = 0;
    words16.delete();
    words12.delete();
  endtask

  task automatic pulse_start(input bit sel12);
    @(posedge clk);
    #1;
    if (sel12) start12 = 1'b1; else start16 = 1'b1;
    tick();
    start12 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done(input bit sel12, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (sel12 ? done12 : done16) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    tick();
  endtask

  task automatic check_run16(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [15:0] fin);
    check({tag, "_nwords"}, words16.size(), 32'd2);
    check({tag, "_w0"}, {24'd0, (words16.size() > 0) ? words16[0] : 8'hxx}, {24'd0, w0});
    check({tag, "_w1"}, {24'd0, (words16.size() > 1) ? words16[1] : 8'hxx}, {24'd0, w1});
    check({tag, "_sc_en_cycles"}, en16, 32'd16);
    check({tag, "_done_pulses"}, dn16, 32'd1);
    check({tag, "_chain"}, {16'd0, chain16}, {16'd0, fin});
    check({tag, "_busy_after"}, {31'd0, busy16}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start16 = 1'b0; start12 = 1'b0; ready16 = 1'b1; ready12 = 1'b1;
    chain16 = 16'hA55A;
    chain12 = 12'hF3C;
    clr_mon();
    #2 reset = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_outs16", {23'd0, sc_en16, valid16, busy16, done16, data16}, 32'd0);
    check("rst_outs12", {23'd0, sc_en12, valid12, busy12, done12, data12}, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_quiet", {28'd0, sc_en16, valid16, done16, busy16}, 32'd0);
    end

    // Basic readback, ready always high
    clr_mon();
    pulse_start(1'b0);
    wait_done(1'b0, 100);
    check_run16("basic", 8'h5A, 8'hA5, 16'hA55A);

    // Back-pressure on the first word
    clr_mon();
    ready16 = 1'b0;
    pulse_start(1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (valid16) seen = 1'b1;
      end
      check("bp_valid_seen", {31'd0, seen}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {22'd0, sc_en16, valid16, data16}, {22'd0, 1'b0, 1'b1, 8'h5A});
    end
    ready16 = 1'b1;
    wait_done(1'b0, 100);
    check_run16("bp", 8'h5A, 8'hA5, 16'hA55A);

    // Partial final word, zero-padded
    clr_mon();
    pulse_start(1'b1);
    wait_done(1'b1, 100);
    check("part_nwords", words12.size(), 32'd2);
    check("part_w0", {24'd0, (words12.size() > 0) ? words12[0] : 8'hxx}, 32'h3C);
    check("part_w1", {24'd0, (words12.size() > 1) ? words12[1] : 8'hxx}, 32'h0F);
    check("part_sc_en_cycles", en12, 32'd12);
    check("part_done_pulses", dn12, 32'd1);
    check("part_chain", {20'd0, chain12}, 32'hF3C);

    // Start while shifting is ignored
    clr_mon();
    pulse_start(1'b0);
    tick(); tick();
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    wait_done(1'b0, 100);
    repeat (20) tick();
    check_run16("restart", 8'h5A, 8'hA5, 16'hA55A);

    // Reset after five captures, then a fresh readback of the rotated chain
    clr_mon();
    pulse_start(1'b0);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("abort_outs", {23'd0, sc_en16, valid16, busy16, done16, data16}, 32'd0);
    check("abort_captures", en16, 32'd5);
    check("abort_chain", {16'd0, chain16}, 32'hD52A);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_needs_start", {30'd0, busy16, sc_en16}, 32'd0);
    end
    clr_mon();
    pulse_start(1'b0);
    wait_done(1'b0, 100);
    check_run16("rot", 8'h2A, 8'hD5, 16'hD52A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_chain_readback.md
CONFIG_CHAIN_READBACK -- requirements
Module: config_chain_readback

Interface
REQ-001 Parameter CHAIN_LEN, default 64, SHALL give the number of configuration flip-flops in the scan chain being read (legal range 1..4096).
REQ-002 Parameter WORD_W, default 8, SHALL give the output word width (legal range 1..32).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request one full chain readback when high in IDLE.
REQ-006 sc_out  input  1  SHALL carry the serial output of the chain tail.
REQ-007 sc_en  output  1  SHALL be the scan-shift enable driven to every chain flip-flop.
REQ-008 sc_in  output  1  SHALL drive the chain head; it equals sc_out (recirculation).
REQ-009 data_o  output  WORD_W  SHALL carry the packed readback word.
REQ-010 valid_o  output  1  SHALL qualify data_o.
REQ-011 ready_i  input  1  SHALL be the consumer acceptance signal.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 done  output  1  SHALL pulse high for exactly one cycle when a readback completes.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, PUSH and DONE.
REQ-015 IDLE -> SHIFT SHALL occur on the first rising edge with start=1; start in any other state SHALL be ignored.
REQ-016 In SHIFT, sc_en SHALL be 1, and each edge SHALL capture sc_out into word bit position k, where k counts 0..WORD_W-1 within the current word (LSB first, chain tail first).
REQ-017 SHIFT -> PUSH SHALL occur after WORD_W captures, or after the last of CHAIN_LEN total captures, whichever comes first.
REQ-018 A final partial word SHALL have its uncaptured upper bits equal to 0.
REQ-019 In PUSH, valid_o SHALL be 1, sc_en SHALL be 0, and data_o SHALL be held stable until the cycle in which ready_i=1.
REQ-020 When valid_o and ready_i are both high, PUSH SHALL go to SHIFT if captures remain, or to DONE otherwise; the word register SHALL clear.
REQ-021 DONE SHALL assert done for one cycle and return to IDLE.
REQ-022 Exactly CHAIN_LEN sc_en-high cycles SHALL occur per readback, so the recirculated chain ends with its original contents.
REQ-023 The total-bit counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide, and the in-word counter ceil(log2(WORD_W+1)) bits wide; neither SHALL wrap.
REQ-024 The block SHALL output ceil(CHAIN_LEN/WORD_W) words per readback.
REQ-025 When start=0, sc_en=0, valid_o=0 and done=0 SHALL hold in IDLE.

Reset
REQ-026 While reset=0, the FSM SHALL be in IDLE, and sc_en, valid_o, busy and done SHALL be 0.
REQ-027 While reset=0, data_o and both counters SHALL be 0.
REQ-028 Reset asserted mid-readback SHALL abort immediately; chain contents are then rotated by the bits already shifted, which is accepted behaviour.
REQ-029 After reset deasserts, the block SHALL need a fresh start pulse.

Structure
REQ-030 Package config_chain_readback_pkg SHALL hold the FSM state typedef and the counter-width helper function.
REQ-031 One sub-module, readback_word_packer, SHALL hold the shift/pack register and the in-word counter; the top module SHALL hold the FSM and the total-bit counter.

Verification
REQ-032 Setup CHAIN_LEN=16, WORD_W=8, chain tail-first bits = 0xA55A, ready_i tied 1 -> words 0x5A then 0xA5, done pulse, 16 sc_en cycles, chain reads 0xA55A afterwards.
REQ-033 Same setup with ready_i=0 for 5 cycles during the first PUSH -> sc_en=0 and data_o=0x5A held stable for those 5 cycles, then the stream resumes unchanged.
REQ-034 Setup CHAIN_LEN=12, WORD_W=8, chain=0xF3C -> words 0x3C then 0x0F (upper 4 bits zero-padded), 12 sc_en cycles.
REQ-035 Pulse start during SHIFT -> no effect; exactly one done pulse and exactly 2 words for CHAIN_LEN=16.
REQ-036 Assert reset after 5 captures -> all outputs 0 immediately; a following start performs a full 16-cycle readback of the 5-bit-rotated chain.
